// File: rtl/serial_adder_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : serial_adder_pkg
//  Description : Shared types and helpers for the bit-serial adder: FSM state
//                enum, trigger counter type and bit-index width helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package serial_adder_pkg;

    // Controller states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Trigger counter width and type
    localparam int c_TRIG_CNT_W = 8;
    typedef logic [c_TRIG_CNT_W-1:0] trig_cnt_t;

    // Bits needed to index 0..width-1 (at least one bit)
    function automatic int idx_width(input int width);
        return (width <= 2) ? 1 : $clog2(width);
    endfunction

endpackage
`default_nettype wire

// File: rtl/full_adder_cell.sv
`default_nettype none
// ============================================================================
//  Module      : full_adder_cell
//  Description : One-bit combinational full adder. When arm is high the carry
//                output is inverted whenever both operand bits are zero.
//  Revision    : 1.0 - initial release
// ============================================================================
module full_adder_cell (
    input  logic x,
    input  logic y,
    input  logic c,
    input  logic arm,
    output logic s,
    output logic carry
);

    logic w_carry_ok;

    // Sum, correct carry and the optionally corrupted carry
    always_comb begin
        s          = x ^ y ^ c;
        w_carry_ok = (x & y) | (c & (x ^ y));
        carry      = w_carry_ok ^ (arm & ~(x | y));
    end

endmodule
`default_nettype wire

// File: rtl/serial_adder_trojan.sv
`default_nettype none
// ============================================================================
//  Module      : serial_adder_trojan
//  Description : Bit-serial WIDTH-bit adder, LSB first, one bit per clock,
//                with valid/ready handshakes on operands and result.
//                Build macro SERIAL_ADDER_TROJAN_EN enables a counter of
//                all-zero transactions that, once it reaches TRIG_COUNT,
//                arms a carry-corrupting payload in the adder cell.
//  Revision    : 1.0 - initial release
// ============================================================================
module serial_adder_trojan
    import serial_adder_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int TRIG_COUNT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int c_IDX_W = idx_width(WIDTH);

    state_t             r_state;
    state_t             w_state_next;
    logic [WIDTH-1:0]   r_a_sh;
    logic [WIDTH-1:0]   r_b_sh;
    logic [WIDTH-1:0]   r_sum;
    logic               r_carry;
    logic               r_cout;
    logic [c_IDX_W-1:0] r_idx;
    logic               w_accept;
    logic               w_last;
    logic               w_s;
    logic               w_carry;
    logic               w_arm;

    assign w_accept = in_valid && (r_state == IDLE);
    assign w_last   = (r_idx == c_IDX_W'(WIDTH - 1));

    // State register
    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_next;
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (in_valid)  w_state_next = RUN;
            RUN:     if (w_last)    w_state_next = DONE;
            DONE:    if (out_ready) w_state_next = IDLE;
            default:                w_state_next = IDLE;
        endcase
    end

    // Handshake outputs decoded from state
    always_comb begin
        in_ready  = (r_state == IDLE);
        out_valid = (r_state == DONE);
    end

    // Datapath: latch operands on accept, one bit step per RUN cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a_sh  <= '0;
            r_b_sh  <= '0;
            r_sum   <= '0;
            r_carry <= 1'b0;
            r_cout  <= 1'b0;
            r_idx   <= '0;
        end else if (w_accept) begin
            r_a_sh  <= a;
            r_b_sh  <= b;
            r_carry <= cin;
            r_idx   <= '0;
        end else if (r_state == RUN) begin
            r_sum   <= {w_s, r_sum[WIDTH-1:1]};
            r_a_sh  <= {1'b0, r_a_sh[WIDTH-1:1]};
            r_b_sh  <= {1'b0, r_b_sh[WIDTH-1:1]};
            r_carry <= w_carry;
            r_idx   <= r_idx + c_IDX_W'(1);
            if (w_last) r_cout <= w_carry;
        end
    end

    full_adder_cell u_cell (
        .x     (r_a_sh[0]),
        .y     (r_b_sh[0]),
        .c     (r_carry),
        .arm   (w_arm),
        .s     (w_s),
        .carry (w_carry)
    );

`ifdef SERIAL_ADDER_TROJAN_EN
    trig_cnt_t r_trig_cnt;
    logic      r_arm;

    // Count all-zero accepts (saturating); arm state is captured from the
    // pre-increment count so the arming transaction itself stays clean
    always_ff @(posedge clk) begin
        if (rst) begin
            r_trig_cnt <= '0;
            r_arm      <= 1'b0;
        end else if (w_accept) begin
            r_arm <= (r_trig_cnt == trig_cnt_t'(TRIG_COUNT));
            if ((a == '0) && (b == '0) && !cin &&
                (r_trig_cnt != trig_cnt_t'(TRIG_COUNT)))
                r_trig_cnt <= r_trig_cnt + trig_cnt_t'(1);
        end
    end

    assign w_arm = r_arm;
`else
    logic [31:0] w_unused_trig_count;
    assign w_unused_trig_count = TRIG_COUNT;
    assign w_arm = 1'b0;
`endif

    assign sum  = r_sum;
    assign cout = r_cout;

endmodule
`default_nettype wire

// File: tb/tb_serial_adder_trojan.sv
`default_nettype none
// ============================================================================
//  Module      : tb_serial_adder_trojan
//  Description : Directed self-checking bench for serial_adder_trojan
//                (WIDTH=8, TRIG_COUNT=4), with random add sweep.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_adder_trojan;

    localparam int WIDTH      = 8;
    localparam int TRIG_COUNT = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] a = '0;
    logic [WIDTH-1:0] b = '0;
    logic             cin = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] sum;
    logic             cout;

    int checks   = 0;
    int failures = 0;

    serial_adder_trojan #(
        .WIDTH      (WIDTH),
        .TRIG_COUNT (TRIG_COUNT)
    ) u_dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout)
    );

    always #5 clk = ~clk;

    task automatic check_value(input string tag, input logic [63:0] obs,
                               input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Issue one add and wait for the result; lat counts edges from the accept
    // edge (inclusive) up to the first edge after which out_valid is high.
    task automatic run_add(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb,
                           input logic tc, input logic release_result,
                           output logic [WIDTH-1:0] rs, output logic rc,
                           output int lat);
        int n;
        n = 0;
        while (!in_ready && n < 50) begin
            tick();
            n++;
        end
        if (!in_ready) check_value("in_ready_timeout", 64'd0, 64'd1);
        a = ta; b = tb; cin = tc; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 100) begin
            tick();
            lat++;
        end
        if (!out_valid) check_value("out_valid_timeout", 64'd0, 64'd1);
        rs = sum;
        rc = cout;
        if (release_result) begin
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
        end
    endtask

    initial begin
        logic [WIDTH-1:0] rs;
        logic             rc;
        int               lat;
        logic [WIDTH:0]   exp9;
        logic [WIDTH-1:0] ra, rb;
        logic             rcin;
        int               n;

        do_reset();
        check_value("reset_in_ready", in_ready, 1);
        check_value("reset_out_valid", out_valid, 0);
        check_value("reset_sum", sum, 0);
        check_value("reset_cout", cout, 0);

        // Basic add and latency
        run_add(8'h5A, 8'h33, 1'b0, 1'b1, rs, rc, lat);
        check_value("basic_sum", rs, 8'h8D);
        check_value("basic_cout", rc, 0);
        check_value("basic_latency", lat, WIDTH + 1);
        check_value("basic_in_ready_back", in_ready, 1);

        // Carry chain cases
        run_add(8'hFF, 8'h00, 1'b1, 1'b1, rs, rc, lat);
        check_value("chain1_sum", rs, 8'h00);
        check_value("chain1_cout", rc, 1);
        run_add(8'hFF, 8'hFF, 1'b1, 1'b1, rs, rc, lat);
        check_value("chain2_sum", rs, 8'hFF);
        check_value("chain2_cout", rc, 1);

        // Backpressure and ignored in_valid during RUN/DONE
        a = 8'h10; b = 8'h20; cin = 1'b0; in_valid = 1'b1;
        tick();
        tick();
        tick();
        a = 8'hAA; b = 8'h55; cin = 1'b1;
        n = 0;
        while (!out_valid && n < 50) begin
            tick();
            n++;
        end
        if (!out_valid) check_value("bp_timeout", 64'd0, 64'd1);
        for (int i = 0; i < 5; i++) begin
            check_value("bp_sum", sum, 8'h30);
            check_value("bp_cout", cout, 0);
            check_value("bp_out_valid", out_valid, 1);
            check_value("bp_in_ready", in_ready, 0);
            tick();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check_value("bp_released_in_ready", in_ready, 1);
        check_value("bp_released_out_valid", out_valid, 0);

        // Reset in the middle of RUN
        a = 8'h77; b = 8'h11; cin = 1'b0; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_value("midrst_in_ready", in_ready, 1);
        check_value("midrst_out_valid", out_valid, 0);
        check_value("midrst_sum", sum, 0);
        check_value("midrst_cout", cout, 0);
        run_add(8'h01, 8'h01, 1'b0, 1'b1, rs, rc, lat);
        check_value("post_rst_sum", rs, 8'h02);
        check_value("post_rst_cout", rc, 0);

        // Random sweep
        for (int i = 0; i < 1000; i++) begin
            ra   = WIDTH'($urandom);
            rb   = WIDTH'($urandom);
            rcin = 1'($urandom);
            exp9 = {1'b0, ra} + {1'b0, rb} + {{WIDTH{1'b0}}, rcin};
            run_add(ra, rb, rcin, 1'b1, rs, rc, lat);
            check_value("rand_sum_cout", {rc, rs}, exp9);
        end

        // Trigger sequence: four clean zero adds, then a fifth
        do_reset();
        for (int i = 0; i < TRIG_COUNT; i++) begin
            run_add(8'h00, 8'h00, 1'b0, 1'b1, rs, rc, lat);
            check_value("zero_sum", rs, 8'h00);
            check_value("zero_cout", rc, 0);
        end
        run_add(8'h00, 8'h00, 1'b0, 1'b1, rs, rc, lat);
`ifdef SERIAL_ADDER_TROJAN_EN
        check_value("armed_sum", rs, 8'hFE);
        check_value("armed_cout", rc, 1);
`else
        check_value("fifth_sum", rs, 8'h00);
        check_value("fifth_cout", rc, 0);
`endif
        do_reset();
        run_add(8'h00, 8'h00, 1'b0, 1'b1, rs, rc, lat);
        check_value("after_rst_zero_sum", rs, 8'h00);
        check_value("after_rst_zero_cout", rc, 0);
        run_add(8'h5A, 8'h33, 1'b0, 1'b1, rs, rc, lat);
        check_value("final_sum", rs, 8'h8D);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/serial_adder_trojan.md
# serial_adder_trojan

Parametrised bit-serial adder: accepts two WIDTH-bit operands plus carry-in through a valid/ready handshake, adds them LSB-first one bit per clock through a single one-bit full-adder cell, and presents a WIDTH-bit sum plus carry-out through a second handshake. It is the sequential successor of the team's combinational trojan-infected full adder. The optional trojan is time-triggered: it arms after a count of rare input events instead of firing combinationally.

## Interface
- WIDTH, 8: operand and sum width in bits; legal values 2..64.
- TRIG_COUNT, 4: number of qualifying transactions that arm the trojan; legal values 1..255; only used when SERIAL_ADDER_TROJAN_EN is defined.
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operand pair and cin are valid.
- in_ready  out  1  block can accept operands; high only in IDLE.
- a  in  WIDTH  augend.
- b  in  WIDTH  addend.
- cin  in  1  carry-in.
- out_valid  out  1  sum and cout are valid; high only in DONE.
- out_ready  in  1  consumer accepts the result.
- sum  out  WIDTH  registered sum.
- cout  out  1  registered carry-out.

## Operation
- States: IDLE, RUN, DONE. On reset: state IDLE, in_ready=1, out_valid=0, sum=0, cout=0, bit index=0, trigger counter=0.
- IDLE: when in_valid && in_ready, latch a, b into shift registers and cin into the carry register, clear the bit index, and go to RUN. Otherwise stay.
- RUN: each cycle, compute the bit-k sum and carry from the LSBs of the shift registers and the carry register, then:
  - shift the sum bit into sum from the MSB side;
  - shift the operands right;
  - update carry;
  - increment k.
  After the step with k=WIDTH-1, load cout with the final carry and go to DONE.
- DONE: hold sum and cout stable. When out_ready is high, go to IDLE. out_ready is ignored in all other states.
- in_valid during RUN or DONE is ignored and operands are not sampled. The producer must hold its data until in_ready is high.
- Arithmetic: {cout, sum} = a + b + cin, computed modulo 2^(WIDTH+1). No overflow flag.
- Bit cell: s = x ^ y ^ c; carry = (x & y) | (c & (x ^ y)).
- rst asserted in any state, including mid-RUN, aborts the operation and restores all reset values on the next edge. A partial sum is never presented.

## Timing
- Accept edge E0. RUN occupies the WIDTH cycles after E0. out_valid is first high in cycle E0+WIDTH+1 (latency WIDTH+1 cycles from accept to result).
- in_ready returns high in the cycle after the out_valid && out_ready edge.
- Minimum issue interval is WIDTH+2 cycles with out_ready held high. No overlap and no pipelining.
- sum and cout change only during RUN and on reset.

## Configuration
- SERIAL_ADDER_TROJAN_EN defined:
  - The trigger counter increments, saturating at TRIG_COUNT, on every accepted transaction with a==0, b==0 and cin==0.
  - When the counter equals TRIG_COUNT, the trojan is armed and the bit-cell carry becomes carry ^ ~(x | y) for the rest of time, until reset.
  - The counter itself increments at the accept edge, so the arming transaction is not affected.
- SERIAL_ADDER_TROJAN_EN undefined:
  - No counter and no payload logic are generated.
  - TRIG_COUNT is unused.
  - The block is a pure correct adder.
- Ports are identical in both builds.

## Structure
- Package serial_adder_pkg holds:
  - the state enum typedef (IDLE, RUN, DONE);
  - the width of the trigger counter type (8 bits);
  - a function computing the bit-index width from WIDTH.
- One sub-module, full_adder_cell: combinational, ports x, y, c, arm → s, carry. The arm input is tied to 0 when the macro is undefined.

## Test plan
- Basic add, WIDTH=8, a=0x5A, b=0x33, cin=0 → sum=0x8D, cout=0, out_valid exactly 9 cycles after accept.
- Full carry chain, a=0xFF, b=0x00, cin=1 → sum=0x00, cout=1. Also a=0xFF, b=0xFF, cin=1 → sum=0xFF, cout=1.
- Backpressure: hold out_ready=0 for 5 cycles in DONE → sum, cout and out_valid stay stable, and in_ready stays 0 throughout. Assert in_valid with new operands during RUN → ignored.
- Reset mid-RUN (edge 4 of 8) → next cycle: state IDLE, out_valid=0, sum=0, cout=0. A following add of 0x01+0x01 → 0x02.
- Trojan build, TRIG_COUNT=4:
  - Four transactions 0+0+0 → each returns sum=0x00, cout=0.
  - A fifth transaction 0x00+0x00+0 → corrupted: sum=0xFE, cout=1.
  - After rst, the same transaction → sum=0x00.
- Trojan-free build, same sequence → all results correct. Random 1000 operand pairs match a+b+cin.
